keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad, synchronises and debounces the row inputs, and decodes a single pressed key to a 4-bit hex code.
- Sits directly upstream of the colour-entry stage. `value` and `ready` feed that stage's `value` and `ready` inputs.
- Emits exactly one `ready` pulse per debounced press. No auto-repeat.

Parameters:
- SCAN_DIV, 4, clock cycles each column is driven (dwell). Must be >= 4 to cover synchroniser latency.
- DEBOUNCE, 3, consecutive identical full sweeps required to accept a press, and consecutive empty sweeps required to accept a release. Must be >= 1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low; low clears all state immediately.
- rows  input  4  keypad row lines, active-low (pulled up); asynchronous to clk.
- cols  output  4  column drive, active-low; exactly one bit low at all times.
- value  output  4  hex code of last accepted key; holds until next accepted press.
- ready  output  1  one-cycle pulse when a new key is accepted.
- held  output  1  high while an accepted key is still considered pressed.

Behaviour:
- Reset values: cols=4'b1110, value=4'h0, ready=0, held=0, state=IDLE. Dwell counter, column index, match/release counters, candidate and sweep accumulator all 0. Row synchroniser flops reset to 4'b1111.
- Synchroniser: rows pass through 2 flops (rows_s) before any use.
- Scan:
  - Column index c (0..3) drives cols = ~(1<<c).
  - Dwell counter counts 0..SCAN_DIV-1. At count SCAN_DIV-1, sample ~rows_s into the accumulator for column c, then advance c (3 wraps to 0).
  - One sweep = 4*SCAN_DIV cycles.
  - A one-cycle internal sweep_done pulse fires the cycle after column 3 is sampled. It carries a classification:
    - NONE: no bits set.
    - SINGLE(k): exactly one bit set.
    - MULTI: two or more bits set.
- Keymap, indexed by row r and column c:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- FSM. Transitions are evaluated only on sweep_done.
  - IDLE:
    - SINGLE(k): cand<=k, match<=1, go DEBOUNCE. If DEBOUNCE==1, accept immediately instead.
    - NONE or MULTI: stay.
  - DEBOUNCE:
    - SINGLE(cand): match+1. When it reaches DEBOUNCE, accept.
    - SINGLE(other): cand<=other, match<=1.
    - NONE or MULTI: go IDLE, match<=0.
  - Accept: value<=cand, ready<=1, held<=1, rel<=0, go HELD. All updates occur on the edge ending the sweep_done cycle, so ready is high for exactly the following cycle.
  - HELD:
    - NONE: rel+1. When rel reaches DEBOUNCE, go IDLE and held<=0 (same edge).
    - SINGLE or MULTI (any key, including a different one): rel<=0, stay, no ready.
- ready is never high for two consecutive cycles.
- Minimum spacing between ready pulses: 2*DEBOUNCE sweeps.
- MULTI never produces ready and never changes value.
- Reset mid-operation: everything returns to reset values asynchronously. A key still held when reset deasserts is treated as a new press and needs a full DEBOUNCE sweeps.
- Counter widths:
  - match and rel: clog2(DEBOUNCE+1) bits.
  - dwell counter: clog2(SCAN_DIV) bits, minimum 1.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE=3 (16 cycles per sweep). The keypad model pulls row r low whenever cols selects the pressed column.
1. Hold key at r2,c2 from reset release → exactly one ready pulse with value=4'h9 and held=1. The pulse comes after the 3rd complete sweep containing the key, within 4 sweeps + 2 cycles of press. No further pulses over 20 more sweeps.
2. Release after scenario 1 → held drops on the 3rd consecutive empty sweep; value stays 4'h9. Then press r3,c1 → ready pulse with value=4'h0.
3. Bounce: key r0,c3 present for 2 sweeps, absent 1, present 2, absent thereafter → no ready, value unchanged, held=0.
4. Candidate change: r1,c0 for 2 sweeps, then r1,c1 for 3 sweeps → one ready with value=4'h5 (never 4'h4).
5. Two keys (r0,c0 and r3,c2) held 10 sweeps → no ready. Then release r3,c2 → ready with value=4'h1 after 3 sweeps.
6. Assert reset (low) mid-DEBOUNCE, and separately during HELD → outputs immediately at reset values (cols=1110, ready=0, held=0, value=0). After release, a held key requires 3 fresh sweeps before ready.

Source files
------------

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad, debounces whole sweeps and decodes one key to hex.
// Latency: ready pulses one cycle after the sweep that completes DEBOUNCE matching sweeps.
// No backpressure: ready is a single-cycle strobe and value holds until the next accepted key.
module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] value,
  output logic       ready,
  output logic       held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_N      = CW'(DEBOUNCE);

  typedef enum logic [1:0] {S_IDLE, S_DEB, S_HELD} state_t;

  logic [3:0]    r_rows_m;
  logic [3:0]    r_rows_s;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_col;
  // Sweep accumulator, laid out as one nibble per column: bit c*4+r.
  logic [15:0]   r_acc;
  logic          r_sweep_done;
  state_t        r_state;
  logic [3:0]    r_cand;
  logic [CW-1:0] r_match;
  logic [CW-1:0] r_rel;

  logic          w_dwell_end;
  logic [4:0]    w_cnt;
  logic [3:0]    w_idx;
  logic [3:0]    w_key;
  logic          w_none;
  logic          w_single;

  // Accumulator bit index (c*4+r) to keypad legend.
  function automatic logic [3:0] keymap(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h4;
      4'd2:    code = 4'h7;
      4'd3:    code = 4'hE;
      4'd4:    code = 4'h2;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h8;
      4'd7:    code = 4'h0;
      4'd8:    code = 4'h3;
      4'd9:    code = 4'h6;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hF;
      4'd12:   code = 4'hA;
      4'd13:   code = 4'hB;
      4'd14:   code = 4'hC;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign cols        = ~(4'b0001 << r_col);
  assign w_dwell_end = (r_dwell == DWELL_LAST);

  // Two-flop synchroniser for the asynchronous row lines (idle = all high).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rows_m <= 4'hF;
      r_rows_s <= 4'hF;
    end else begin
      r_rows_m <= rows;
      r_rows_s <= r_rows_m;
    end
  end

  // Column scan: dwell on each column, sample its rows at the end of the dwell.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dwell      <= '0;
      r_col        <= 2'd0;
      r_acc        <= 16'h0000;
      r_sweep_done <= 1'b0;
    end else begin
      r_sweep_done <= w_dwell_end && (r_col == 2'd3);
      if (w_dwell_end) begin
        r_dwell                   <= '0;
        r_col                     <= r_col + 2'd1;
        r_acc[{r_col, 2'b00} +: 4] <= ~r_rows_s;
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
    end
  end

  // Classify the completed sweep: number of keys seen and which one (if single).
  always_comb begin
    w_cnt = 5'd0;
    w_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (r_acc[i]) begin
        w_cnt = w_cnt + 5'd1;
        w_idx = 4'(i);
      end
    end
  end

  assign w_none   = (w_cnt == 5'd0);
  assign w_single = (w_cnt == 5'd1);
  assign w_key    = keymap(w_idx);

  // Press/release debounce FSM, advanced once per sweep, with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cand  <= 4'h0;
      r_match <= '0;
      r_rel   <= '0;
      value   <= 4'h0;
      ready   <= 1'b0;
      held    <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (r_sweep_done) begin
        case (r_state)
          S_IDLE: begin
            if (w_single) begin
              if (DEBOUNCE == 1) begin
                value   <= w_key;
                ready   <= 1'b1;
                held    <= 1'b1;
                r_rel   <= '0;
                r_match <= '0;
                r_state <= S_HELD;
              end else begin
                r_cand  <= w_key;
                r_match <= CW'(1);
                r_state <= S_DEB;
              end
            end
          end
          S_DEB: begin
            if (w_single) begin
              if (w_key == r_cand) begin
                if (r_match + CW'(1) == DEB_N) begin
                  value   <= r_cand;
                  ready   <= 1'b1;
                  held    <= 1'b1;
                  r_rel   <= '0;
                  r_match <= '0;
                  r_state <= S_HELD;
                end else begin
                  r_match <= r_match + CW'(1);
                end
              end else begin
                // A different single key restarts the count on the new candidate.
                r_cand  <= w_key;
                r_match <= CW'(1);
              end
            end else begin
              r_match <= '0;
              r_state <= S_IDLE;
            end
          end
          S_HELD: begin
            if (w_none) begin
              if (r_rel + CW'(1) == DEB_N) begin
                r_rel   <= '0;
                held    <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_rel <= r_rel + CW'(1);
              end
            end else begin
              // Any contact, even a different key, keeps the press alive.
              r_rel <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad model driving rows from cols, sweep-level reference model.
// Stimulus changes the pressed-key set only at sweep boundaries it tracks by its own edge count.
// Directed scenarios first, then a randomized key-set sequence, then one summary line.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] value;
  logic       ready;
  logic       held;

  int total;
  int bad;
  int ecnt;

  // Pressed keys, bit r*4+c.
  logic [15:0] keys;

  // Reference model state.
  logic [3:0] km [16];
  logic [3:0] m_value;
  logic       m_held;
  logic       m_rdy;
  int         m_run;
  int         m_last;
  int         m_empty;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk   (clk),
    .reset (reset),
    .rows  (rows),
    .cols  (cols),
    .value (value),
    .ready (ready),
    .held  (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to the driven-low column.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] kk(input int r, input int c);
    return 16'h0001 << (r*4 + c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock, sampled 1ns after the edge; the active column follows the bench's own edge count.
  task automatic tick();
    int col;
    @(posedge clk);
    #1;
    ecnt++;
    col = (ecnt % 16) / 4;
    chk("cols", {28'd0, cols}, {28'd0, ~(4'b0001 << col)});
  endtask

  task automatic model_reset();
    m_value = 4'h0;
    m_held  = 1'b0;
    m_rdy   = 1'b0;
    m_run   = 0;
    m_last  = -1;
    m_empty = 0;
  endtask

  // Apply the press/release rules to one sweep that saw key set k.
  task automatic model_sweep(input logic [15:0] k);
    int n;
    int idx;
    n   = $countones(k);
    idx = -1;
    for (int i = 0; i < 16; i++) if (k[i]) idx = i;
    m_rdy = 1'b0;
    if (!m_held) begin
      if (n == 1) begin
        m_run  = (m_run > 0 && idx == m_last) ? m_run + 1 : 1;
        m_last = idx;
        if (m_run == 3) begin
          m_rdy   = 1'b1;
          m_held  = 1'b1;
          m_value = km[idx];
          m_run   = 0;
          m_empty = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (n == 0) begin
        m_empty++;
        if (m_empty == 3) begin
          m_held  = 1'b0;
          m_empty = 0;
          m_run   = 0;
        end
      end else begin
        m_empty = 0;
      end
    end
  endtask

  // Hold key set k for one full sweep; check no stray pulse, then the sweep's outcome.
  task automatic sweep(input logic [15:0] k);
    int pulses;
    keys   = k;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (ready) pulses++;
    end
    chk("ready_mid_sweep", pulses, 0);
    tick();
    model_sweep(k);
    chk("ready", {31'd0, ready}, {31'd0, m_rdy});
    chk("value", {28'd0, value}, {28'd0, m_value});
    chk("held", {31'd0, held}, {31'd0, m_held});
  endtask

  task automatic sweeps(input logic [15:0] k, input int n);
    for (int i = 0; i < n; i++) sweep(k);
  endtask

  // Asynchronous reset a few cycles into a sweep, then realign to a fresh sweep.
  task automatic do_reset();
    for (int i = 0; i < 5; i++) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_cols", {28'd0, cols}, 32'hE);
    chk("rst_value", {28'd0, value}, 32'h0);
    chk("rst_ready", {31'd0, ready}, 32'h0);
    chk("rst_held", {31'd0, held}, 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    ecnt  = 0;
    tick();
  endtask

  initial begin
    logic [15:0] k;
    int          kind;
    int          a;
    int          b;
    total = 0;
    bad   = 0;
    ecnt  = 0;
    keys  = 16'h0000;
    reset = 1'b0;
    km = '{4'h1, 4'h2, 4'h3, 4'hA,
           4'h4, 4'h5, 4'h6, 4'hB,
           4'h7, 4'h8, 4'h9, 4'hC,
           4'hE, 4'h0, 4'hF, 4'hD};
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("init_cols", {28'd0, cols}, 32'hE);
    chk("init_value", {28'd0, value}, 32'h0);
    chk("init_ready", {31'd0, ready}, 32'h0);
    chk("init_held", {31'd0, held}, 32'h0);
    reset = 1'b1;
    tick();

    // Key 9 held from reset release, then held long with no repeat.
    sweeps(kk(2, 2), 3);
    chk("s1_ready", {31'd0, ready}, 32'h1);
    chk("s1_value", {28'd0, value}, 32'h9);
    sweeps(kk(2, 2), 20);
    chk("s1_held", {31'd0, held}, 32'h1);

    // Release: held falls on the third empty sweep, value kept; then key 0.
    sweeps(16'h0000, 2);
    chk("s2_still_held", {31'd0, held}, 32'h1);
    sweep(16'h0000);
    chk("s2_released", {31'd0, held}, 32'h0);
    chk("s2_value_kept", {28'd0, value}, 32'h9);
    sweeps(kk(3, 1), 3);
    chk("s2_value0", {28'd0, value}, 32'h0);
    sweeps(16'h0000, 3);

    // Bounce never reaches three consecutive sweeps.
    sweeps(kk(0, 3), 2);
    sweep(16'h0000);
    sweeps(kk(0, 3), 2);
    sweeps(16'h0000, 3);
    chk("s3_value", {28'd0, value}, 32'h0);
    chk("s3_held", {31'd0, held}, 32'h0);

    // Candidate change restarts the count on the new key.
    sweeps(kk(1, 0), 2);
    sweeps(kk(1, 1), 3);
    chk("s4_value", {28'd0, value}, 32'h5);
    sweeps(16'h0000, 3);

    // Two keys never accepted; dropping one leaves a valid single press.
    sweeps(kk(0, 0) | kk(3, 2), 10);
    chk("s5_multi_held", {31'd0, held}, 32'h0);
    sweeps(kk(0, 0), 3);
    chk("s5_value", {28'd0, value}, 32'h1);
    sweeps(16'h0000, 3);

    // Reset mid-debounce and during held; the still-pressed key is a fresh press.
    sweeps(kk(2, 0), 2);
    do_reset();
    sweeps(kk(2, 0), 2);
    chk("s6_no_early", {31'd0, held}, 32'h0);
    sweep(kk(2, 0));
    chk("s6_value7", {28'd0, value}, 32'h7);
    sweep(kk(2, 0));
    do_reset();
    sweeps(kk(2, 0), 3);
    chk("s6_value7b", {28'd0, value}, 32'h7);
    sweeps(16'h0000, 3);

    // Randomized key-set sequence with frequent repeats so presses get accepted.
    k = 16'h0000;
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        kind = int'($urandom_range(0, 5));
        a    = int'($urandom_range(0, 15));
        b    = (a + 1 + int'($urandom_range(0, 14))) % 16;
        if (kind < 2)       k = 16'h0000;
        else if (kind < 5)  k = 16'h0001 << a;
        else                k = (16'h0001 << a) | (16'h0001 << b);
      end
      sweep(k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
